// File: rtl/booth_r4_multiplier.sv
// booth_r4_multiplier
// Sequential radix-4 Booth multiplier with a start/busy/done handshake.
// Each operand is extended to WIDTH+2 bits, by sign or by zeros as selected by sgn.
// Every operation then takes exactly WIDTH/2+1 Booth steps, whatever the mode.
//
// Ports:
//   clk     - clock, rising edge
//   rst     - synchronous active-low reset
//   St      - start request; accepted only while idle
//   sgn     - 1: two's-complement operands, 0: unsigned (sampled with St)
//   Mplier  - multiplier operand (sampled with St)
//   Mcand   - multiplicand operand (sampled with St)
//   busy    - high while an operation is in progress
//   done    - one-cycle pulse when product has been updated
//   product - 2*WIDTH-bit result, held until the next completion
module booth_r4_multiplier #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 St,
   input  logic                 sgn,
   input  logic [WIDTH-1:0]     Mplier,
   input  logic [WIDTH-1:0]     Mcand,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int unsigned ITER = WIDTH / 2 + 1;
   localparam int unsigned EW   = WIDTH + 2;  // extended operand width
   localparam int unsigned AW   = WIDTH + 4;  // accumulator width, holds +/-2M
   localparam int unsigned CW   = $clog2(ITER + 1);

   generate
      if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_bad_width
         $error("booth_r4_multiplier: WIDTH must be even and >= 4");
      end
   endgenerate

   typedef enum logic [0:0] {StIdle, StCalc} state_e;

   state_e               state_q, state_d;
   logic [AW-1:0]        acc_q, acc_d;
   logic [EW-1:0]        mq_q, mq_d;     // multiplier, shifts out as steps retire
   logic                 q1_q, q1_d;     // appended bit b[-1]
   logic [EW-1:0]        mc_q, mc_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   prod_q, prod_d;
   logic                 done_q, done_d;

   logic [2:0]           triplet;
   logic [AW-1:0]        m1, m2, pp, sum, acc_sh;
   logic [EW-1:0]        mq_sh;

   // Booth step datapath: select partial product, add, then shift the
   // combined {acc, mq, q1} register right arithmetically by two.
   always_comb begin
      triplet = {mq_q[1:0], q1_q};
      m1      = {{2{mc_q[EW-1]}}, mc_q};
      m2      = {mc_q[EW-1], mc_q, 1'b0};
      pp      = '0;
      case (triplet)
         3'b001, 3'b010: pp = m1;
         3'b011:         pp = m2;
         3'b100:         pp = ~m2 + 1'b1;
         3'b101, 3'b110: pp = ~m1 + 1'b1;
         default:        pp = '0;
      endcase
      sum    = acc_q + pp;
      acc_sh = {{2{sum[AW-1]}}, sum[AW-1:2]};
      mq_sh  = {sum[1:0], mq_q[EW-1:2]};
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      mq_d    = mq_q;
      q1_d    = q1_q;
      mc_d    = mc_q;
      cnt_d   = cnt_q;
      prod_d  = prod_q;
      done_d  = 1'b0;
      busy    = (state_q == StCalc);

      unique case (state_q)
         StIdle: begin
            if (St) begin
               mq_d    = sgn ? {{2{Mplier[WIDTH-1]}}, Mplier} : {2'b00, Mplier};
               mc_d    = sgn ? {{2{Mcand[WIDTH-1]}}, Mcand} : {2'b00, Mcand};
               acc_d   = '0;
               q1_d    = 1'b0;
               cnt_d   = '0;
               state_d = StCalc;
            end
         end
         StCalc: begin
            acc_d = acc_sh;
            mq_d  = mq_sh;
            q1_d  = mq_q[1];
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(ITER - 1)) begin
               // After the last shift mq holds the low EW product bits.
               prod_d  = {acc_sh[WIDTH-3:0], mq_sh};
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= StIdle;
         acc_q   <= '0;
         mq_q    <= '0;
         q1_q    <= 1'b0;
         mc_q    <= '0;
         cnt_q   <= '0;
         prod_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         mq_q    <= mq_d;
         q1_q    <= q1_d;
         mc_q    <= mc_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
         done_q  <= done_d;
      end
   end

   assign done    = done_q;
   assign product = prod_q;

endmodule
